// File: rtl/sevenseg_scan.sv
// Four-digit seven-segment scan controller. It blanks the display between digits
// and swaps in a new display value only at frame boundaries.
module sevenseg_scan #(
   parameter int unsigned REFRESH_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value_in,
   input  logic        load,
   input  logic [3:0]  digit_en,
   input  logic        lz_blank,
   output logic [3:0]  num,
   output logic [3:0]  an,
   output logic [1:0]  digit_idx,
   output logic        frame_done
);

   localparam int unsigned CW = $clog2(BLANK_CYCLES + REFRESH_CYCLES);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);

   logic [0:0]    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    idx_nxt;
   logic [15:0]   disp, disp_nxt;
   logic [15:0]   shadow, shadow_nxt;
   logic          pending, pending_nxt;
   logic          boundary;
   logic          lz_zero;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_BLANK;
         cnt       <= '0;
         digit_idx <= 2'd0;
         disp      <= 16'h0000;
         shadow    <= 16'h0000;
         pending   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         digit_idx <= idx_nxt;
         disp      <= disp_nxt;
         shadow    <= shadow_nxt;
         pending   <= pending_nxt;
      end
   end

   // Slot sequencing and frame-synchronous value transfer
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + CW'(1);
      idx_nxt     = digit_idx;
      disp_nxt    = disp;
      shadow_nxt  = shadow;
      pending_nxt = pending;
      boundary    = (state == ST_SHOW) && (cnt == REFRESH_LAST) && (digit_idx == 2'd3);

      case (state)
         ST_BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_nxt = ST_SHOW;
               cnt_nxt   = '0;
            end
         end
         default: begin
            if (cnt == REFRESH_LAST) begin
               state_nxt = ST_BLANK;
               cnt_nxt   = '0;
               idx_nxt   = digit_idx + 2'd1;
            end
         end
      endcase

      // The old shadow moves at the boundary; a coincident load queues for the next frame
      if (boundary && pending) begin
         disp_nxt    = shadow;
         pending_nxt = 1'b0;
      end
      if (load) begin
         shadow_nxt  = value_in;
         pending_nxt = 1'b1;
      end
   end

   // Anode decode uses live enable and leading-zero controls
   always_comb begin
      case (digit_idx)
         2'd1:    lz_zero = (disp[15:4] == 12'h000);
         2'd2:    lz_zero = (disp[15:8] == 8'h00);
         2'd3:    lz_zero = (disp[15:12] == 4'h0);
         default: lz_zero = 1'b0;
      endcase

      an = 4'b1111;
      if ((state == ST_SHOW) && digit_en[digit_idx] && !(lz_blank && lz_zero))
         an[digit_idx] = 1'b0;

      num        = disp[{digit_idx, 2'b00} +: 4];
      frame_done = boundary;
   end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed scoreboard bench for sevenseg_scan using REFRESH=4 and BLANK=2, which gives a 24-cycle frame.
module tb_sevenseg_scan;

   logic        clk;
   logic        rst_n;
   logic [15:0] value_in;
   logic        load;
   logic [3:0]  digit_en;
   logic        lz_blank;
   logic [3:0]  num;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        frame_done;

   sevenseg_scan #(.REFRESH_CYCLES(4), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value_in   (value_in),
      .load       (load),
      .digit_en   (digit_en),
      .lz_blank   (lz_blank),
      .num        (num),
      .an         (an),
      .digit_idx  (digit_idx),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] num;
      logic [1:0] idx;
      logic       fd;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          t = 0;
   logic [15:0] m_disp = 16'h0;
   logic [15:0] m_shadow = 16'h0;
   logic        m_pend = 1'b0;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
      end
   endtask

   // Cycle-position model: slot = pos/6, lit phase = last 4 cycles of each slot
   task automatic tick(input logic ld, input logic [15:0] v);
      int   pos, slot, ph;
      logic lit;
      exp_t e, o;
      load     = ld;
      value_in = v;
      pos  = t % 24;
      slot = pos / 6;
      ph   = pos % 6;
      lit  = (ph >= 2) && digit_en[slot] &&
             !(lz_blank && (slot >= 1) && ((m_disp >> (4 * slot)) == 16'h0));
      e.an  = lit ? ~(4'b0001 << slot) : 4'b1111;
      e.num = 4'(m_disp >> (4 * slot));
      e.idx = 2'(slot);
      e.fd  = (pos == 23);
      sb.push_back(e);
      #1;
      o = sb.pop_front();
      check("an", an, o.an);
      check("num", num, o.num);
      check("digit_idx", {2'b00, digit_idx}, {2'b00, o.idx});
      check("frame_done", {3'b000, frame_done}, {3'b000, o.fd});
      if (pos == 23 && m_pend) begin
         m_disp = m_shadow;
         m_pend = 1'b0;
      end
      if (ld) begin
         m_shadow = v;
         m_pend   = 1'b1;
      end
      t++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 16'h0000);
   endtask

   task automatic run_to(input int p);
      do tick(1'b0, 16'h0000); while ((t % 24) != p);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      @(posedge clk);
      #1;
      check("rst_an", an, 4'b1111);
      check("rst_num", num, 4'h0);
      check("rst_idx", {2'b00, digit_idx}, 4'h0);
      check("rst_fd", {3'b000, frame_done}, 4'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      m_disp   = 16'h0;
      m_shadow = 16'h0;
      m_pend   = 1'b0;
      t        = 0;
   endtask

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      value_in = 16'h0;
      digit_en = 4'b1111;
      lz_blank = 1'b0;
      do_reset();

      // Frame 0 shows zeros while 1A2F waits; frame 1 shows F,2,A,1
      run_to(5);
      tick(1'b1, 16'h1A2F);
      run_to(0);
      run_cycles(24);

      // Double load in the same frame: the last value wins
      run_to(3);
      tick(1'b1, 16'h1111);
      run_to(10);
      tick(1'b1, 16'h2222);
      run_to(0);
      run_cycles(24);

      // A load at the boundary queues behind the pending value
      run_to(5);
      tick(1'b1, 16'h4444);
      run_to(23);
      tick(1'b1, 16'h3333);
      run_cycles(48);

      // Leading-zero blanking
      tick(1'b1, 16'h0050);
      run_to(0);
      lz_blank = 1'b1;
      run_cycles(24);
      lz_blank = 1'b0;
      run_cycles(24);
      tick(1'b1, 16'h0000);
      run_to(0);
      lz_blank = 1'b1;
      run_cycles(24);

      // Enable mask, followed by a reset in the middle of digit 3 while a load is pending
      lz_blank = 1'b0;
      digit_en = 4'b1010;
      tick(1'b1, 16'hBEEF);
      run_to(0);
      run_to(20);
      tick(1'b1, 16'h7777);
      do_reset();
      digit_en = 4'b1111;
      run_cycles(48);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
